// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
//   Multiplies use one shift-add step per cycle, divides use one restoring
//   step per cycle on operand magnitudes; signs are reapplied at the end.
//   Divide-by-zero and signed overflow are resolved in a single cycle.
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   Start          request, accepted only while Busy=0
//   Op[2:0]        funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   Word           32-bit W-variant select (meaningful only when BIT_COUNT=64)
//   OpA, OpB       multiplicand/dividend, multiplier/divisor
//   Flush          abort of the in-flight operation
//   Busy           operation in flight
//   Done           one-cycle pulse, Result valid
//   Result         operation result, held until the next completion
module muldiv_unit #(
  parameter int BIT_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  input  logic [2:0]           Op,
  input  logic                 Word,
  input  logic [BIT_COUNT-1:0] OpA,
  input  logic [BIT_COUNT-1:0] OpB,
  input  logic                 Flush,
  output logic                 Busy,
  output logic                 Done,
  output logic [BIT_COUNT-1:0] Result
);

  localparam int W  = BIT_COUNT;
  localparam int CW = 7;

  if (BIT_COUNT != 32 && BIT_COUNT != 64) begin : g_bad_width
    $error("muldiv_unit: BIT_COUNT must be 32 or 64");
  end

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  function automatic logic [W-1:0] sext32(input logic [31:0] x);
    logic [W-1:0] y;
    y       = '0;
    y[31:0] = x;
    for (int i = 32; i < W; i++) y[i] = x[31];
    return y;
  endfunction

  function automatic logic [W-1:0] zext32(input logic [31:0] x);
    logic [W-1:0] y;
    y       = '0;
    y[31:0] = x;
    return y;
  endfunction

  // W-variant results are the low 32 bits sign-extended to the full width.
  function automatic logic [W-1:0] word_fix(input logic wd, input logic [W-1:0] x);
    return wd ? sext32(x[31:0]) : x;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    result_q, result_d;
  logic            load;

  // Operation context latched at acceptance.
  logic [2:0]      op_q;
  logic            word_q;
  logic            neg_q;     // product / quotient must be negated
  logic            rneg_q;    // remainder must be negated

  // Multiply datapath.
  logic [2*W-1:0]  acc_q, mcand_q;
  logic [W-1:0]    mplier_q;
  // Divide datapath.
  logic [W-1:0]    rem_q, quo_q, dsr_q;

  // Operand preparation for a Start in IDLE.
  logic            word_eff, a_sgn_op, b_sgn_op, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [W-1:0]    a_ext, b_ext, a_mag, b_mag, min_neg, special_res;
  logic [CW-1:0]   n_val;

  always_comb begin
    // Word is meaningless for the high-half multiplies.
    word_eff = (W == 64) && Word && (Op[2] || (Op[1:0] == 2'b00));
    a_sgn_op = (Op == 3'b001) || (Op == 3'b010) || (Op == 3'b100) || (Op == 3'b110);
    b_sgn_op = (Op == 3'b001) || (Op == 3'b100) || (Op == 3'b110);
    a_ext    = word_eff ? (a_sgn_op ? sext32(OpA[31:0]) : zext32(OpA[31:0])) : OpA;
    b_ext    = word_eff ? (b_sgn_op ? sext32(OpB[31:0]) : zext32(OpB[31:0])) : OpB;
    a_neg    = a_sgn_op && a_ext[W-1];
    b_neg    = b_sgn_op && b_ext[W-1];
    a_mag    = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag    = b_neg ? (~b_ext + 1'b1) : b_ext;
    n_val    = word_eff ? CW'(32) : CW'(W);
    min_neg  = word_eff ? sext32(32'h8000_0000) : {1'b1, {(W-1){1'b0}}};
    div_zero = Op[2] && (b_ext == '0);
    div_ovf  = Op[2] && !Op[0] && (a_ext == min_neg) && (b_ext == '1);
    if (div_zero) special_res = Op[1] ? a_ext : '1;
    else          special_res = Op[1] ? '0 : a_ext;
    special_res = word_fix(word_eff, special_res);
  end

  // One iteration of each algorithm, plus the signed/word-adjusted result
  // that becomes visible when the final iteration completes.
  logic [2*W-1:0]  acc_nx, prod;
  logic [W:0]      rem_sh, rem_sub;
  logic [W-1:0]    rem_nx, quo_nx, quo_s, rem_s, raw, fin;
  logic            qbit;

  always_comb begin
    acc_nx  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    rem_sh  = {rem_q, quo_q[W-1]};
    rem_sub = rem_sh - {1'b0, dsr_q};
    qbit    = (rem_sh >= {1'b0, dsr_q});
    rem_nx  = qbit ? rem_sub[W-1:0] : rem_sh[W-1:0];
    quo_nx  = {quo_q[W-2:0], qbit};
    prod    = neg_q ? (~acc_nx + 1'b1) : acc_nx;
    quo_s   = neg_q ? (~quo_nx + 1'b1) : quo_nx;
    rem_s   = rneg_q ? (~rem_nx + 1'b1) : rem_nx;
    if (op_q[2])               raw = op_q[1] ? rem_s : quo_s;
    else if (op_q[1:0] == 2'b00) raw = prod[W-1:0];
    else                       raw = prod[2*W-1:W];
    fin     = word_fix(word_q, raw);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          load = 1'b1;
          if (div_zero || div_ovf) begin
            state_d  = FINISH;
            result_d = special_res;
          end else begin
            state_d = RUN;
            cnt_d   = n_val - CW'(1);
          end
        end
      end
      RUN: begin
        if (Flush) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d  = FINISH;
          result_d = fin;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (load) begin
      op_q     <= Op;
      word_q   <= word_eff;
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      acc_q    <= '0;
      mcand_q  <= {{W{1'b0}}, a_mag};
      mplier_q <= b_mag;
      rem_q    <= '0;
      // Left-align the dividend so the first step sees its top bit for N=32 too.
      quo_q    <= word_eff ? (a_mag << (W - 32)) : a_mag;
      dsr_q    <= b_mag;
    end else if (state_q == RUN) begin
      acc_q    <= acc_nx;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      rem_q    <= rem_nx;
      quo_q    <= quo_nx;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule
